// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch controller.
//   state_t        : controller state encoding (also the value on the 'state' port)
//   HALT_INSTR_DEF : default halt instruction word (ECALL)
//   WORD_SHIFT     : shift that turns a word index into a byte address
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_0073;
  localparam int          WORD_SHIFT     = 2;

endpackage

// File: rtl/imem_pc_reg.sv
// Program counter register for the fetch controller.
//   clk, rst     : clock, synchronous active-high reset (pc -> RESET_PC)
//   init         : reload RESET_PC (start of a run)
//   run          : pc may advance this cycle (controller is fetching and not stopping)
//   stall        : hold the current pc
//   redirect     : take redirect_pc (wins over stall)
//   redirect_pc  : redirect target
//   pc           : current program counter
//   misaligned   : redirect target is not word aligned; pc then holds
import imem_pkg::*;

module imem_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        misaligned
);

  localparam logic [31:0] STEP = 32'd1 << WORD_SHIFT;

  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // Priority: redirect > stall > increment. A misaligned redirect freezes the
  // pc so the faulting instruction's address stays visible.
  always_ff @(posedge clk) begin
    if (rst || init) begin
      pc <= RESET_PC;
    end else if (run) begin
      if (redirect) begin
        if (!misaligned) pc <= redirect_pc;
      end else if (!stall) begin
        pc <= pc + STEP;
      end
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory port owner: time-shares the memory between a word-serial
// program loader and the CPU fetch path.
//   clk, rst                          : clock, synchronous active-high reset
//   load_start/valid/data/last/ready  : loader stream (words written from address 0)
//   run_start                         : begin fetching from RESET_PC (IDLE only)
//   stall, redirect, redirect_pc      : datapath flow control for the next pc
//   mem_addr/we/wdata, mem_rdata      : InstructionMemory port (comb read, sync write)
//   pc, instr, instr_valid            : fetch result for the current cycle
//   state                             : IDLE=0, LOAD=1, RUN=2, HALT=3
//   fault                             : sticky address / load-overflow fault
import imem_pkg::*;

module imem_fetch_ctrl #(
  parameter int          DEPTH      = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        run_start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [1:0]  state,
  output logic        fault
);

  // One extra bit so the counter can reach DEPTH and flag overflow.
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH) << WORD_SHIFT;

  state_t          st, st_nxt;
  logic [CW-1:0]   cnt;
  logic            fault_q;
  logic [31:0]     pc_q;
  logic            misaligned;
  logic            oob, load_ovf, halt_hit;
  logic            pc_init, pc_run;
  logic            set_fault, enter_load, word_wr;

  assign oob      = (pc_q >= LIMIT);
  assign load_ovf = load_valid && (cnt == CW'(DEPTH));
  // A halt only retires when it would actually execute: valid, unstalled and
  // not overridden by a redirect in the same cycle.
  assign halt_hit = (st == ST_RUN) && !oob && !redirect && !stall &&
                    (mem_rdata == HALT_INSTR);

  assign pc_init    = (st == ST_IDLE) && run_start && !load_start;
  assign pc_run     = (st == ST_RUN) && !oob && !halt_hit;
  assign enter_load = (st != ST_LOAD) && (st_nxt == ST_LOAD);
  assign word_wr    = (st == ST_LOAD) && load_valid && !load_ovf;

  imem_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk         (clk),
    .rst         (rst),
    .init        (pc_init),
    .run         (pc_run),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc_q),
    .misaligned  (misaligned)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  // Next state
  always_comb begin
    st_nxt    = st;
    set_fault = 1'b0;
    case (st)
      ST_IDLE: begin
        if (load_start)     st_nxt = ST_LOAD;
        else if (run_start) st_nxt = ST_RUN;
      end
      ST_LOAD: begin
        if (load_valid) begin
          if (load_ovf) begin
            st_nxt    = ST_HALT;
            set_fault = 1'b1;
          end else if (load_last) begin
            st_nxt = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        if (oob || (redirect && misaligned)) begin
          st_nxt    = ST_HALT;
          set_fault = 1'b1;
        end else if (halt_hit) begin
          st_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (load_start) st_nxt = ST_LOAD;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Load counter and sticky fault; a reload restarts both.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      fault_q <= 1'b0;
    end else if (enter_load) begin
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      if (word_wr)   cnt     <= cnt + CW'(1);
      if (set_fault) fault_q <= 1'b1;
    end
  end

  // Port muxing
  always_comb begin
    load_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc_q;
    mem_wdata   = 32'h0;
    instr       = 32'h0;
    instr_valid = 1'b0;
    case (st)
      ST_LOAD: begin
        load_ready = 1'b1;
        mem_addr   = 32'(cnt) << WORD_SHIFT;
        mem_wdata  = load_data;
        // Reset is synchronous, so suppress the write in the reset cycle itself.
        mem_we     = load_valid && !load_ovf && !rst;
      end
      ST_RUN: begin
        instr       = mem_rdata;
        instr_valid = !oob;
      end
      default: ;
    endcase
  end

  assign state = st;
  assign pc    = pc_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  localparam int          DEPTH = 64;
  localparam logic [31:0] HALTW = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 0, load_valid = 0, load_last = 0, run_start = 0;
  logic        stall = 0, redirect = 0;
  logic [31:0] load_data = 0, redirect_pc = 0;
  logic        load_ready, mem_we, instr_valid, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instr;
  logic [1:0]  state;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0), .HALT_INSTR(HALTW)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .run_start(run_start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .state(state), .fault(fault)
  );

  // InstructionMemory stand-in: combinational read, synchronous write.
  logic [31:0] imem [DEPTH];
  assign mem_rdata = (mem_addr < 32'(DEPTH * 4)) ? imem[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) if (mem_we) imem[mem_addr[7:2]] <= mem_wdata;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the controller is doing, expressed as the
  // specification's rules over plain variables and an expected memory image.
  int          m_state = 0;   // 0 IDLE, 1 LOAD, 2 RUN, 3 HALT
  logic [31:0] m_pc = 0;
  int          m_cnt = 0;
  bit          m_fault = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_addr, e_wdata, e_instr;
  bit          e_we, e_ready, e_valid;

  always @(negedge clk) begin
    if (chk_en) begin
      e_addr = m_pc; e_wdata = 0; e_instr = 0; e_we = 0; e_ready = 0; e_valid = 0;
      if (m_state == 1) begin
        e_ready = 1;
        e_addr  = 32'(m_cnt * 4);
        e_wdata = load_data;
        e_we    = load_valid && (m_cnt < DEPTH) && !rst;
      end else if (m_state == 2) begin
        e_valid = (m_pc < 32'(DEPTH * 4));
        e_instr = e_valid ? m_mem[m_pc[7:2]] : 32'h0;
      end
      chk("state",       32'(state),       32'(m_state));
      chk("pc",          pc,               m_pc);
      chk("mem_addr",    mem_addr,         e_addr);
      chk("mem_we",      32'(mem_we),      32'(e_we));
      chk("mem_wdata",   mem_wdata,        e_wdata);
      chk("load_ready",  32'(load_ready),  32'(e_ready));
      chk("instr",       instr,            e_instr);
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("fault",       32'(fault),       32'(m_fault));
      // advance to the state after the coming clock edge
      if (rst) begin
        m_state = 0; m_pc = 0; m_cnt = 0; m_fault = 0;
      end else begin
        case (m_state)
          0: if (load_start) begin m_state = 1; m_cnt = 0; m_fault = 0; end
             else if (run_start) begin m_state = 2; m_pc = 0; end
          1: if (load_valid) begin
               if (m_cnt == DEPTH) begin m_fault = 1; m_state = 3; end
               else begin
                 m_mem[m_cnt] = load_data;
                 m_cnt++;
                 if (load_last) m_state = 0;
               end
             end
          2: if (!e_valid) begin m_fault = 1; m_state = 3; end
             else if (redirect) begin
               if (redirect_pc[1:0] != 2'b00) begin m_fault = 1; m_state = 3; end
               else m_pc = redirect_pc;
             end else if (!stall) begin
               if (e_instr == HALTW) m_state = 3;
               else m_pc = m_pc + 4;
             end
          default: if (load_start) begin m_state = 1; m_cnt = 0; m_fault = 0; end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1; load_data = d; load_last = last;
    step();
    load_valid = 0; load_last = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin imem[i] = 0; m_mem[i] = 0; end
    step();
    chk_en = 1;
    step();
    rst = 0;
    chk("rst state", 32'(state), 32'd0);
    chk("rst pc", pc, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst load_ready", 32'(load_ready), 32'd0);

    // three-word program
    load_start = 1; step(); load_start = 0;
    load_word(32'h0050_0093, 0);
    load_word(32'h0010_8113, 0);
    load_word(32'h0000_0073, 1);
    chk("load done state", 32'(state), 32'd0);
    chk("load done ready", 32'(load_ready), 32'd0);
    chk("imem0", imem[0], 32'h0050_0093);
    chk("imem1", imem[1], 32'h0010_8113);
    chk("imem2", imem[2], 32'h0000_0073);

    // run to halt
    run_start = 1; step(); run_start = 0;
    chk("run pc0", pc, 32'h0);
    chk("run valid0", 32'(instr_valid), 32'd1);
    chk("run instr0", instr, 32'h0050_0093);
    step(); chk("run pc1", pc, 32'h4);
    step(); chk("run pc2", pc, 32'h8);
    chk("run instr2", instr, 32'h0000_0073);
    step();
    chk("halt state", 32'(state), 32'd3);
    chk("halt pc", pc, 32'h8);
    chk("halt fault", 32'(fault), 32'd0);

    // stall, redirect-over-stall, misaligned redirect
    rst = 1; step(); rst = 0;
    run_start = 1; step(); run_start = 0;
    step();
    stall = 1; step(); step();
    chk("stall pc", pc, 32'h4);
    chk("stall instr", instr, 32'h0010_8113);
    redirect = 1; redirect_pc = 32'h10; step();
    redirect = 0; stall = 0;
    chk("redirect pc", pc, 32'h10);
    redirect = 1; redirect_pc = 32'h6; step();
    redirect = 0;
    chk("misalign state", 32'(state), 32'd3);
    chk("misalign fault", 32'(fault), 32'd1);
    chk("misalign pc", pc, 32'h10);

    // full image of non-halt words, then run off the end
    load_start = 1; step(); load_start = 0;
    chk("reload fault clr", 32'(fault), 32'd0);
    for (int i = 0; i < DEPTH; i++) load_word(32'h0000_0013, (i == DEPTH - 1));
    chk("full load state", 32'(state), 32'd0);
    run_start = 1; step(); run_start = 0;
    redirect = 1; redirect_pc = 32'hFC; step(); redirect = 0;
    chk("pc fc", pc, 32'hFC);
    step();
    chk("pc 100", pc, 32'h100);
    chk("oob valid", 32'(instr_valid), 32'd0);
    step();
    chk("oob state", 32'(state), 32'd3);
    chk("oob fault", 32'(fault), 32'd1);
    chk("oob pc", pc, 32'h100);

    // 65 words without last: overflow
    load_start = 1; step(); load_start = 0;
    for (int i = 0; i <= DEPTH; i++) load_word(32'hA000_0000 + 32'(i), 0);
    chk("ovf state", 32'(state), 32'd3);
    chk("ovf fault", 32'(fault), 32'd1);
    chk("ovf imem63", imem[63], 32'hA000_003F);
    load_start = 1; step(); load_start = 0;
    chk("ovf reload fault", 32'(fault), 32'd0);
    chk("ovf reload state", 32'(state), 32'd1);
    chk("ovf reload addr", mem_addr, 32'h0);

    // reset mid-LOAD with a word presented
    load_word(32'hB000_0000, 0);
    load_word(32'hB000_0001, 0);
    chk("midload addr", mem_addr, 32'h8);
    rst = 1; load_valid = 1; load_data = 32'hDEAD_BEEF; step();
    rst = 0; load_valid = 0;
    chk("midload rst state", 32'(state), 32'd0);
    chk("midload rst pc", pc, 32'h0);
    chk("midload no write", imem[2], 32'hA000_0002);

    // reset mid-RUN
    run_start = 1; step(); run_start = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("midrun rst state", 32'(state), 32'd0);
    chk("midrun rst pc", pc, 32'h0);

    // load_start beats run_start
    load_start = 1; run_start = 1; step(); load_start = 0; run_start = 0;
    chk("both start state", 32'(state), 32'd1);
    load_word(32'h0000_0073, 1);
    chk("final state", 32'(state), 32'd0);
    step();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
